// File: rtl/oro_pkg.sv
// oro_pkg: shared types and constants for the oroboro mailbox arbiter
package oro_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} oro_state_e;
  localparam int ORO_DW = 32;
  localparam logic [ORO_DW-1:0] ORO_TO_DATA = 32'hDEAD_BEEF;
  typedef logic [ORO_DW-1:0] oro_word_t;
endpackage

// File: rtl/oro_rr_pick.sv
// oro_rr_pick: combinational round-robin selector, first request at or after ptr
module oro_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            any,
  output logic [2:0]      idx
);
  logic [NREQ-1:0] rot;
  logic [2:0]      off;
  logic [3:0]      sum;
  assign rot = NREQ'({req, req} >> ptr);
  assign any = |req;
  assign sum = 4'(ptr) + 4'(off);
  assign idx = sum >= 4'(NREQ) ? 3'(sum - 4'(NREQ)) : sum[2:0];
  // lowest set bit of the rotated vector is the nearest requester after ptr
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? 3'(i) : off;
  end
endmodule

// File: rtl/oro_mailbox_arbiter.sv
// oro_mailbox_arbiter: round-robin sharing of one VM mailbox channel with response timeout
module oro_mailbox_arbiter
  import oro_pkg::*;
#(
  parameter int             NREQ    = 4,
  parameter int             DW      = ORO_DW,
  parameter int             TIMEOUT = 1000,
  parameter logic [DW-1:0]  TO_DATA = DW'(ORO_TO_DATA)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_timeout,
  output logic               mb_req_valid,
  output logic [DW-1:0]      mb_req_data,
  output logic [2:0]         mb_req_id,
  input  logic               mb_req_ready,
  input  logic               mb_rsp_valid,
  input  logic [DW-1:0]      mb_rsp_data,
  output logic               mb_rsp_ready,
  output logic               busy,
  output logic [7:0]         stale_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  oro_state_e    state_q, state_d;
  logic [2:0]    gnt_q, gnt_d, rr_q, rr_d, pick;
  logic [DW-1:0] req_q, req_d, rsp_q, rsp_d, sel_data;
  logic [TW-1:0] timer_q, timer_d;
  logic          to_q, to_d, any, accept, expired;
  logic [7:0]    stale_q, stale_d;
  oro_rr_pick #(.NREQ(NREQ)) u_pick (.req(req_valid), .ptr(rr_q), .any(any), .idx(pick));
  assign accept       = state_q == IDLE && any && !reset;
  assign expired      = timer_q == TW'(TIMEOUT - 1);
  assign req_ready    = accept ? NREQ'(1) << pick : '0;
  assign rsp_valid    = state_q == RESP ? NREQ'(1) << gnt_q : '0;
  assign rsp_data     = rsp_q;
  assign rsp_timeout  = state_q == RESP && to_q;
  assign mb_req_valid = state_q == ISSUE;
  assign mb_req_data  = req_q;
  assign mb_req_id    = gnt_q;
  assign mb_rsp_ready = !reset;
  assign busy         = state_q != IDLE;
  assign stale_cnt    = stale_q;
  // payload of the requester the selector is pointing at
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) sel_data = pick == 3'(k) ? req_data[k*DW +: DW] : sel_data;
  end
  // transaction sequencing: grant, issue, wait with timeout, deliver
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    timer_d = timer_q;
    to_d    = to_q;
    stale_d = mb_rsp_valid && state_q != WAIT && stale_q != 8'hFF ? stale_q + 8'd1 : stale_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        gnt_d   = pick;
        req_d   = sel_data;
      end
      ISSUE: if (mb_req_ready) begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        state_d = mb_rsp_valid || expired ? RESP : WAIT;
        rsp_d   = mb_rsp_valid ? mb_rsp_data : expired ? TO_DATA : rsp_q;
        to_d    = !mb_rsp_valid && expired;
      end
      default: begin
        state_d = IDLE;
        rr_d    = gnt_q == 3'(NREQ - 1) ? 3'd0 : gnt_q + 3'd1;
      end
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
      timer_q <= '0;
      to_q    <= 1'b0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      stale_q <= stale_d;
    end
  end
endmodule

// File: tb/tb_oro_mailbox_arbiter.sv
// tb_oro_mailbox_arbiter: scoreboard bench with a request-level reference model
module tb_oro_mailbox_arbiter;
  localparam int TO = 10;
  logic         clk, reset;
  logic [3:0]   req_valid, req_ready, rsp_valid;
  logic [127:0] req_data;
  logic [31:0]  rsp_data, mb_req_data, mb_rsp_data;
  logic         rsp_timeout, mb_req_valid, mb_req_ready, mb_rsp_valid, mb_rsp_ready, busy;
  logic [2:0]   mb_req_id;
  logic [7:0]   stale_cnt;
  typedef struct {int id; logic [31:0] d;} iss_t;
  typedef struct {int id; logic [31:0] d; logic to;} rsp_t;
  iss_t iq[$];
  rsp_t rq[$];
  int checks = 0, errors = 0, rr_m = 0, stale_m = 0;
  logic [127:0] pl;

  oro_mailbox_arbiter #(.NREQ(4), .DW(32), .TIMEOUT(TO), .TO_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .mb_req_valid(mb_req_valid), .mb_req_data(mb_req_data), .mb_req_id(mb_req_id),
    .mb_req_ready(mb_req_ready), .mb_rsp_valid(mb_rsp_valid), .mb_rsp_data(mb_rsp_data),
    .mb_rsp_ready(mb_rsp_ready), .busy(busy), .stale_cnt(stale_cnt));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int pick_m(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(rr_m + i) % 4]) return (rr_m + i) % 4;
    return -1;
  endfunction

  // Reference: grant = nearest requester at/after the pointer; a reply k cycles into
  // the wait is delivered if k < TO, otherwise the timeout word goes back and the
  // reply itself lands later as stale.
  task automatic txn(input logic [3:0] m, input logic [127:0] p, input int rdy_dly,
                     input int k, input logic [31:0] rd);
    int g, lat;
    g = pick_m(m);
    rr_m = (g + 1) % 4;
    iq.push_back('{g, p[g*32 +: 32]});
    rq.push_back('{g, k < TO ? rd : 32'hDEAD_BEEF, k >= TO});
    if (k >= TO) stale_m++;
    @(negedge clk);
    req_valid = m;
    req_data  = p;
    #1 chk("req_ready", req_ready, 64'(4'b0001 << g));
    for (int r = 0; r <= rdy_dly; r++) begin
      @(negedge clk);
      req_valid    = '0;
      mb_req_ready = (r == rdy_dly);
    end
    lat = 0;
    for (int n = 1; n <= 60 && !(lat != 0 && n > k + 2); n++) begin
      @(negedge clk);
      mb_req_ready = 0;
      mb_rsp_valid = (n == k + 1);
      mb_rsp_data  = rd;
      #1 if (lat == 0 && rsp_valid != 0) lat = n;
    end
    mb_rsp_valid = 0;
    chk("rsp_latency", 64'(lat), 64'(k < TO ? k + 2 : TO + 1));
    @(negedge clk);
    #1 chk("busy_after", 64'(busy), 64'(0));
    chk("stale_cnt", 64'(stale_cnt), 64'(stale_m));
  endtask

  // monitor: compare every issued request and delivered response to the scoreboard
  always @(negedge clk) begin
    #2;
    if (!reset && mb_req_valid) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL issue_unexpected: id %0d data %0h with empty queue", mb_req_id, mb_req_data);
      end else begin
        chk("mb_req_id", 64'(mb_req_id), 64'(iq[0].id));
        chk("mb_req_data", 64'(mb_req_data), 64'(iq[0].d));
        if (mb_req_ready) void'(iq.pop_front());
      end
    end
    if (!reset && rsp_valid != 0) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: rsp_valid %b data %0h with empty queue", rsp_valid, rsp_data);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.id));
        chk("rsp_data", 64'(rsp_data), 64'(e.d));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  end

  initial begin
    reset = 1; req_valid = 0; req_data = 0;
    mb_req_ready = 0; mb_rsp_valid = 0; mb_rsp_data = 0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_timeout, mb_req_valid, mb_req_id,
                                 mb_rsp_ready, busy, stale_cnt}), 64'(0));
    chk("reset_data", {rsp_data, mb_req_data}, 64'(0));
    reset = 0;
    // single request on requester 1
    txn(4'b0010, {4{32'h0000_1234}}, 0, 3, 32'h0000_5678);
    // reset-to-start round robin with everyone requesting
    reset = 1;
    @(negedge clk);
    reset = 0; rr_m = 0; stale_m = 0;
    for (int t = 0; t < 8; t++) begin
      pl = {$urandom, $urandom, $urandom, $urandom};
      txn(4'b1111, pl, t % 2, 2, $urandom);
    end
    // timeout with a late reply, then reply in the expiry cycle, then reply landing in RESP
    txn(4'b0100, {$urandom, $urandom, $urandom, $urandom}, 0, 15, 32'h1111_2222);
    txn(4'b1000, {$urandom, $urandom, $urandom, $urandom}, 0, TO - 1, 32'h3333_4444);
    txn(4'b0001, {$urandom, $urandom, $urandom, $urandom}, 1, TO, 32'h5555_6666);
    // long mailbox backpressure, no timeout in ISSUE
    txn(4'b0110, {$urandom, $urandom, $urandom, $urandom}, 20, 4, 32'h7777_8888);
    // reset while waiting: no response, later reply is stale
    pl = {$urandom, $urandom, $urandom, $urandom};
    iq.push_back('{2, pl[64 +: 32]});
    @(negedge clk);
    req_valid = 4'b0100; req_data = pl;
    #1 chk("rst_req_ready", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    req_valid = 0; mb_req_ready = 1;
    @(negedge clk);
    mb_req_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; rr_m = 0; stale_m = 0;
    #1 chk("midwait_reset_outputs", 64'({req_ready, rsp_valid, rsp_timeout, mb_req_valid, mb_req_id,
                                         busy, stale_cnt}), 64'(0));
    chk("midwait_reset_data", {rsp_data, mb_req_data}, 64'(0));
    @(negedge clk);
    mb_rsp_valid = 1; mb_rsp_data = 32'hABCD_0000;
    @(negedge clk);
    mb_rsp_valid = 0;
    stale_m = 1;
    repeat (2) @(negedge clk);
    #1 chk("midwait_stale", 64'(stale_cnt), 64'(stale_m));
    chk("midwait_busy", 64'(busy), 64'(0));
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      pl = {$urandom, $urandom, $urandom, $urandom};
      txn(4'($urandom_range(1, 15)), pl, $urandom_range(0, 3), $urandom_range(0, 14), $urandom);
    end
    repeat (3) @(negedge clk);
    chk("issue_queue_empty", 64'(iq.size()), 64'(0));
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/oro_mailbox_arbiter.md
Name: oro_mailbox_arbiter

Overview:
- Shares the single 32-bit co-simulation mailbox channel to the external oroboro VM among NREQ Verilog-side requesters.
- Arbitrates round-robin, issues one transaction at a time, waits for the VM response and routes it back to the granted requester.
- Bounds each wait with a timeout.
- Sits between testbench-side agents (clock/stimulus drivers, monitors) and the mailbox bridge that forwards to the VM.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, request/response data width.
- TIMEOUT, 1000, max cycles in WAIT before the transaction is abandoned (>=2).
- TO_DATA, 32'hDEAD_BEEF, response data returned on timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*DW  request payloads; requester k uses bits [k*DW +: DW].
- req_ready  out  NREQ  one-hot accept pulse to the granted requester.
- rsp_valid  out  NREQ  one-hot response valid, 1 cycle.
- rsp_data  out  DW  response payload; valid only with rsp_valid.
- rsp_timeout  out  1  high with rsp_valid when the response is a timeout.
- mb_req_valid  out  1  mailbox request valid.
- mb_req_data  out  DW  mailbox request payload.
- mb_req_id  out  3  index of the requester being served.
- mb_req_ready  in  1  mailbox accepts the request.
- mb_rsp_valid  in  1  VM response valid.
- mb_rsp_data  in  DW  VM response payload.
- mb_rsp_ready  out  1  arbiter accepts the response.
- busy  out  1  high in any state other than IDLE.
- stale_cnt  out  8  count of dropped late responses; saturates at 255.

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0, rr pointer 0, timer 0, stale_cnt 0. Reset mid-transaction abandons it with no response; the VM's eventual reply is dropped as stale.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no req_valid: stay in IDLE.
- IDLE, any req_valid:
  - Grant the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Same cycle: req_ready[g]=1, latch req_data[g] and g, go to ISSUE.
  - Request-accept latency is 0 cycles (combinational ready in IDLE).
- ISSUE:
  - mb_req_valid=1 with the latched data; mb_req_id=g.
  - Hold stable until mb_req_ready; on the handshake go to WAIT and clear the timer.
  - No timeout applies in ISSUE.
- WAIT:
  - mb_rsp_ready=1; timer increments each cycle.
  - On mb_rsp_valid: latch mb_rsp_data, go to RESP.
  - If the timer reaches TIMEOUT-1 with no response: latch TO_DATA, set the timeout flag, go to RESP.
  - If a response arrives in the same cycle the timer expires, the response wins and the flag stays clear.
- RESP:
  - One cycle: rsp_valid[g]=1, rsp_data and rsp_timeout driven.
  - rr_ptr <= (g+1) mod NREQ; go to IDLE.
  - Requesters must accept the response unconditionally (no backpressure).
- Stale responses: in IDLE, ISSUE and RESP, mb_rsp_ready=1; any mb_rsp_valid there is dropped and stale_cnt increments, saturating at 255.
- Fairness: a requester holding req_valid is granted within NREQ transactions.
- A requester deasserting req_valid before its grant is simply skipped.
- Back-to-back throughput: one transaction per (3 + mailbox latency) cycles minimum.
- mb_req_data and mb_req_id are held stable during ISSUE and are don't-care otherwise (drive the latched values).

Decomposition:
- Shared package oro_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - constant ORO_DW=32;
  - constant ORO_TO_DATA=32'hDEAD_BEEF;
  - typedef oro_word_t.
- One sub-module, oro_rr_pick: combinational round-robin selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, grant index.
- FSM, timer and counters stay in oro_mailbox_arbiter.

Test Plan:
- Single request: req_valid=4'b0010, data 32'h0000_1234; mailbox ready immediately, response 32'h0000_5678 after 3 cycles -> req_ready[1] pulse, mb_req_id=1, rsp_valid=4'b0010 with rsp_data=32'h5678, rsp_timeout=0, busy falls next cycle.
- Round-robin: all four req_valid held high for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3; each requester gets rsp_valid exactly twice.
- Timeout: TIMEOUT=10, VM never responds -> rsp_valid on the granted requester 10 cycles after entering WAIT, rsp_data=32'hDEAD_BEEF, rsp_timeout=1; a later VM response increments stale_cnt to 1.
- Simultaneous expiry: response arrives on the cycle the timer reaches TIMEOUT-1 -> real data delivered, rsp_timeout=0, stale_cnt unchanged.
- Mailbox backpressure: mb_req_ready held low for 20 cycles -> mb_req_valid/data/id stable throughout; no timeout; normal completion afterwards.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> next cycle all outputs 0 and state IDLE; a subsequent VM response gives stale_cnt=1 and no rsp_valid.
